// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch front end for a single-cycle core. It owns the fetch PC, issues one
// sequential word fetch at a time to instruction memory, buffers returned
// words with their PCs in a small circular prefetch queue, and presents the
// queue head downstream with a valid/ready handshake. A redirect from the core
// reloads the fetch PC and flushes both the queue and any in-flight fetch.
//
// Ports:
//   clock               system clock, rising edge
//   rst                 asynchronous active-low reset
//   imem_req/imem_addr  fetch strobe and word-aligned address (no grant)
//   imem_rvalid/rdata   in-order response, at least one cycle after request
//   redirect_valid/pc   load a new fetch target this cycle
//   redirect_misaligned one-cycle pulse: last redirect target had pc[1:0]!=0
//   if_valid/instr/pc   queue head towards decode
//   if_ready            downstream consumes head when if_valid && if_ready
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        redirect_misaligned,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          run_q, run_d;          // holds off the first fetch until one cycle after reset release
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;  // address of the outstanding fetch
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [31:0]   instr_mem_d [QDEPTH];
  logic [31:0]   pc_mem_q    [QDEPTH];
  logic [31:0]   pc_mem_d    [QDEPTH];
  logic [31:0]   head_instr_q, head_instr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          mis_q, mis_d;
  logic          push_s;
  logic          pop_s;

  assign imem_addr           = fetch_pc_q;
  assign if_valid            = (count_q != CNT_ZERO);
  assign if_instr            = head_instr_q;
  assign if_pc               = head_pc_q;
  assign redirect_misaligned = mis_q;

  // Fetch FSM, prefetch queue bookkeeping and redirect handling.
  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    instr_mem_d  = instr_mem_q;
    pc_mem_d     = pc_mem_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    mis_d        = 1'b0;
    imem_req     = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        // Registered count only: a slot freed by this cycle's pop is usable next cycle.
        if (run_q && !redirect_valid && (count_q < QDEPTH_C)) begin
          imem_req   = 1'b1;
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // A concurrent redirect still retires the fetch, but its data is discarded.
          push_s  = !redirect_valid;
          state_d = ST_ISSUE;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    pop_s = (count_q != CNT_ZERO) && if_ready && !redirect_valid;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      mis_d      = (redirect_pc[1:0] != 2'b00);
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
    end else begin
      if (push_s) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = pend_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end

    // Head registers track the next head (including a word written this cycle);
    // when the queue drains they keep their last value.
    if (count_d != CNT_ZERO) begin
      head_instr_d = instr_mem_d[rd_ptr_d];
      head_pc_d    = pc_mem_d[rd_ptr_d];
    end else begin
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ISSUE;
      run_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= 32'h0000_0000;
      rd_ptr_q     <= PTR_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      instr_mem_q  <= '{default: 32'h0000_0000};
      pc_mem_q     <= '{default: 32'h0000_0000};
      head_instr_q <= 32'h0000_0000;
      head_pc_q    <= 32'h0000_0000;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      instr_mem_q  <= instr_mem_d;
      pc_mem_q     <= pc_mem_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      mis_q        <= mis_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized phase. A memory model answers fetches with data = addr + 0x100,
// and a stream monitor predicts fetch addresses and delivered (pc, instr).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 2;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        redirect_misaligned;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 1;   // 0 selects a random latency of 1..3
  bit poison = 1'b0; // memory answers 0xDEAD while set
  int consumed = 0;
  int nreq;
  int rst_cnt;
  logic [31:0] got0, got1;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clock(clock), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_misaligned(redirect_misaligned),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, input int budget, input bit no_dead);
    for (int i = 0; i < budget && if_valid !== 1'b1; i++) begin
      sample();
      if (no_dead) chk("no_dead", 32'(if_instr == 32'h0000_DEAD), 32'd0);
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && imem_req !== 1'b1; i++) sample();
    chk("wait_req", 32'(imem_req), 32'd1);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    repeat (4) step();
    sample();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    step();
    rst = 1'b1;
  endtask

  // Memory model: one response per request, latency counted in cycles.
  initial begin : mem_model
    logic [31:0] a;
    int lat;
    forever begin
      @(negedge clock);
      if (rst === 1'b1 && imem_req === 1'b1) begin
        a = imem_addr;
        lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
        for (int i = 0; i < lat; i++) begin
          @(posedge clock);
          #1;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = poison ? 32'h0000_DEAD : a + 32'h0000_0100;
        @(posedge clock);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
      end
    end
  end

  // Stream reference: sequential fetch from the last target, data = pc + 0x100.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  logic        mis_exp = 1'b0;
  always @(negedge clock) begin
    if (rst !== 1'b1) begin
      chk("mon_rst_req", 32'(imem_req), 32'd0);
      chk("mon_rst_addr", imem_addr, RESET_PC);
      chk("mon_rst_valid", 32'(if_valid), 32'd0);
      chk("mon_rst_instr", if_instr, 32'd0);
      chk("mon_rst_pc", if_pc, 32'd0);
      chk("mon_rst_mis", 32'(redirect_misaligned), 32'd0);
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
      mis_exp   = 1'b0;
    end else begin
      chk("mon_mis", 32'(redirect_misaligned), 32'(mis_exp));
      if (imem_req === 1'b1) begin
        chk("mon_fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (if_valid === 1'b1 && if_ready === 1'b1 && redirect_valid !== 1'b1) begin
        chk("mon_if_pc", if_pc, exp_pc);
        chk("mon_if_instr", if_instr, exp_pc + 32'h0000_0100);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid === 1'b1) begin
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_fetch = {redirect_pc[31:2], 2'b00};
        mis_exp   = (redirect_pc[1:0] != 2'b00);
      end else begin
        mis_exp = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) step();

    // Sequential fetch with k=1, consumer always ready.
    if_ready = 1'b1;
    mem_lat  = 1;
    do_reset();
    sample(); chk("t1_c0_req", 32'(imem_req), 32'd0);
    sample(); chk("t1_c1_req", 32'(imem_req), 32'd1); chk("t1_c1_addr", imem_addr, 32'h0);
    sample(); chk("t1_c2_valid", 32'(if_valid), 32'd0);
    sample(); chk("t1_c3_valid", 32'(if_valid), 32'd1);
    chk("t1_pc0", if_pc, 32'h0); chk("t1_instr0", if_instr, 32'h100);
    chk("t1_c3_addr", imem_addr, 32'h4);
    sample(); chk("t1_c4_valid", 32'(if_valid), 32'd0);
    sample(); chk("t1_pc4", if_pc, 32'h4); chk("t1_instr4", if_instr, 32'h104);
    sample(); sample(); chk("t1_pc8", if_pc, 32'h8); chk("t1_instr8", if_instr, 32'h108);

    // Consumer stalled: queue fills with exactly QDEPTH fetches.
    if_ready = 1'b0;
    do_reset();
    nreq = 0; got0 = 32'hFFFF_FFFF; got1 = 32'hFFFF_FFFF;
    repeat (10) begin
      sample();
      if (imem_req === 1'b1) begin
        if (nreq == 0) got0 = imem_addr;
        else if (nreq == 1) got1 = imem_addr;
        nreq++;
      end
    end
    chk("t2_nreq", 32'(nreq), 32'd2);
    chk("t2_addr0", got0, 32'h0);
    chk("t2_addr1", got1, 32'h4);
    chk("t2_head_pc", if_pc, 32'h0);
    step(); if_ready = 1'b1;
    sample(); chk("t2_pop_req", 32'(imem_req), 32'd0); chk("t2_pop_pc", if_pc, 32'h0);
    sample(); chk("t2_next_req", 32'(imem_req), 32'd1); chk("t2_next_addr", imem_addr, 32'h8);
    chk("t2_second_pc", if_pc, 32'h4);

    // Redirect while waiting; the late 0xDEAD response must be dropped.
    mem_lat = 2; poison = 1'b1;
    do_reset();
    step();
    step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    sample();
    step(); redirect_valid = 1'b0; mem_lat = 1;
    sample(); chk("t3_drop_req", 32'(imem_req), 32'd0); chk("t3_drop_valid", 32'(if_valid), 32'd0);
    step(); poison = 1'b0;
    sample(); chk("t3_req", 32'(imem_req), 32'd1); chk("t3_addr", imem_addr, 32'h200);
    wait_valid("t3_wait_valid", 10, 1'b1);
    chk("t3_pc", if_pc, 32'h200); chk("t3_instr", if_instr, 32'h300);

    // Misaligned redirect.
    step(); redirect_valid = 1'b1; redirect_pc = 32'h303;
    sample(); chk("t4_mis_before", 32'(redirect_misaligned), 32'd0);
    step(); redirect_valid = 1'b0;
    sample(); chk("t4_mis_pulse", 32'(redirect_misaligned), 32'd1);
    chk("t4_flushed", 32'(if_valid), 32'd0);
    step();
    sample(); chk("t4_mis_after", 32'(redirect_misaligned), 32'd0);
    wait_valid("t4_wait_valid", 10, 1'b0);
    chk("t4_pc", if_pc, 32'h300); chk("t4_instr", if_instr, 32'h400);

    // PC wrap at the top of the address space.
    step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    sample(); chk("t5_flushed", 32'(if_valid), 32'd0);
    wait_valid("t5_wait_top", 10, 1'b0);
    chk("t5_pc_top", if_pc, 32'hFFFF_FFFC); chk("t5_instr_top", if_instr, 32'h0000_00FC);
    sample();
    wait_valid("t5_wait_wrap", 10, 1'b0);
    chk("t5_pc_wrap", if_pc, 32'h0); chk("t5_instr_wrap", if_instr, 32'h100);

    // Reset during an outstanding fetch; stale response arrives during reset.
    step(); mem_lat = 3;
    sample();
    wait_req(10);
    step(); rst = 1'b0;
    repeat (6) begin
      sample();
      chk("t6_rst_valid", 32'(if_valid), 32'd0);
      chk("t6_rst_req", 32'(imem_req), 32'd0);
      chk("t6_rst_pc", if_pc, 32'h0);
    end
    step(); rst = 1'b1; mem_lat = 1;
    sample(); chk("t6_c0_valid", 32'(if_valid), 32'd0);
    sample(); chk("t6_c1_req", 32'(imem_req), 32'd1); chk("t6_c1_addr", imem_addr, RESET_PC);
    chk("t6_c1_valid", 32'(if_valid), 32'd0);
    sample(); sample();
    chk("t6_pc", if_pc, RESET_PC); chk("t6_instr", if_instr, RESET_PC + 32'h100);

    // Randomized traffic: latency, back-pressure, redirects and resets.
    mem_lat = 0;
    consumed = 0;
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      redirect_valid = 1'b0;
      if (rst == 1'b0) begin
        if (rst_cnt > 0) rst_cnt--;
        else rst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        rst_cnt = 5;
      end else if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 2))
          0: redirect_pc = $urandom();
          1: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
          default: redirect_pc = $urandom_range(0, 32'h0000_0FFF);
        endcase
      end
      if_ready = ($urandom_range(0, 3) != 0);
    end
    step(); redirect_valid = 1'b0; rst = 1'b1; if_ready = 1'b1;
    repeat (20) step();
    sample();
    chk("rand_progress", 32'(consumed > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle core's decode/execute path.
- Owns the fetch PC and issues sequential word fetches to instruction memory.
- Buffers returned instructions with their PCs in a small prefetch queue and hands them downstream through a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) from the core, which flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 2: prefetch queue entries; power of two, range 2..8.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  single-cycle fetch request strobe.
- imem_addr  out  32  word-aligned fetch address, valid when imem_req=1.
- imem_rvalid  in  1  response strobe; in order, at least 1 cycle after its request.
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
- redirect_valid  in  1  load a new fetch PC this cycle.
- redirect_pc  in  32  new fetch target.
- redirect_misaligned  out  1  registered pulse; the last redirect had pc[1:0]!=0.
- if_valid  out  1  queue head holds an instruction.
- if_instr  out  32  head instruction.
- if_pc  out  32  PC of the head instruction.
- if_ready  in  1  downstream consumes the head when if_valid && if_ready.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue count=0; state=ISSUE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, redirect_misaligned=0.
  - Any in-flight response is forgotten.
  - imem_rvalid arriving while rst=0 is ignored.
- Outstanding requests: at most one. Memory accepts imem_req unconditionally; there is no grant.
- FSM states ISSUE, WAIT, DROP:
  - ISSUE: if count < QDEPTH and no redirect this cycle → imem_req=1, imem_addr=fetch_pc, fetch_pc+=4, go WAIT. Otherwise stay, imem_req=0.
  - WAIT: on imem_rvalid → push {fetch address, imem_rdata} at queue tail, go ISSUE.
  - DROP: on imem_rvalid → discard data, go ISSUE.
  - A request may issue in the same cycle the queue frees a slot only via the registered count, i.e. one cycle after the pop.
- Redirect, highest priority, same edge:
  - Queue flushed (count=0); any pop or push in that cycle is cancelled.
  - fetch_pc = {redirect_pc[31:2],2'b00}; redirect_misaligned=1 for one cycle if redirect_pc[1:0]!=0.
  - State: from WAIT → DROP, or to ISSUE if imem_rvalid is also high that cycle (response discarded). From DROP → DROP, or ISSUE if imem_rvalid is high. ISSUE → ISSUE with no request that cycle.
  - First request to the new target is issued the cycle after the redirect.
- Queue:
  - Circular buffer with rd/wr pointers of width log2(QDEPTH) and count of width log2(QDEPTH)+1.
  - if_valid = (count!=0); if_instr/if_pc driven from the head entry registers.
  - Pop and push in the same cycle: count unchanged, both pointers advance.
  - Overflow is impossible: issue is gated on count<QDEPTH, with one outstanding request max.
  - Pop while empty is ignored.
- Latency: request at cycle N, response at N+k (k≥1), if_valid high from N+k+1.
  - Sustained throughput with k=1 is one instruction per 2 cycles (single outstanding).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- if_instr/if_pc hold their value while if_valid=0; no X leaks out after reset.

Test Plan:
- Reset release, RESET_PC=0, memory returns mem[a]=a+32'h100 at k=1, if_ready=1 → imem_addr sequence 0,4,8…; if_pc/if_instr pairs (0,0x100), (4,0x104), (8,0x108); first if_valid 3 cycles after reset release.
- if_ready=0 for 10 cycles → exactly QDEPTH=2 requests issued (0,4), then imem_req stays 0. Raise if_ready → pops 0 then 4; next request (8) one cycle after the first pop.
- Redirect to 0x200 while in WAIT, response arrives next cycle with data 0xDEAD → 0xDEAD never appears on if_instr; queue empty; next imem_addr=0x200; first if_pc=0x200.
- Redirect to 0x303 → imem_addr=0x300, redirect_misaligned pulses exactly one cycle, if_pc=0x300.
- Redirect to 0xFFFF_FFFC with k=1 → if_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- rst asserted mid-WAIT, then memory's stale rvalid arrives during reset → ignored; after release, first fetch is at RESET_PC; all outputs are at reset values while rst=0.
